// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and active-window helper.
package vga_pkg;

  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_CLK_DIV  = 2;

  localparam int unsigned H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Visible-window test on raw counters for the default mode.
  function automatic logic in_active(coord_t x, coord_t y);
    return (x >= coord_t'(DEF_H_SYNC + DEF_H_BP)) &&
           (x <  coord_t'(DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE)) &&
           (y >= coord_t'(DEF_V_SYNC + DEF_V_BP)) &&
           (y <  coord_t'(DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE));
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bus: counters, syncs, active flag and strobes.
interface vga_timing_if;
  import vga_pkg::*;

  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pixel_tick;
  logic   line_start;
  logic   frame_start;

  modport master (
    output pixel_x, pixel_y, hsync, vsync, video_on,
           pixel_tick, line_start, frame_start
  );

  modport slave (
    input  pixel_x, pixel_y, hsync, vsync, video_on,
           pixel_tick, line_start, frame_start
  );
endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider and 2-flop reset synchroniser for the raster generator.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_arm_n,
  output logic rst_sync_n,
  output logic pixel_tick,
  output logic tick_next_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  // rst_arm_n leads rst_sync_n by one cycle so output registers can preload (0,0) state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_arm_n  <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_arm_n  <= 1'b1;
      rst_sync_n <= rst_arm_n;
    end
  end

  always_comb begin
    div_next = '0;
    if (rst_sync_n && (div_cnt != DIV_LAST)) begin
      div_next = div_cnt + DIV_W'(1);
    end
  end

  assign tick_next_c = (div_next == DIV_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      div_cnt    <= '0;
      pixel_tick <= (CLK_DIV == 1);
    end else begin
      div_cnt    <= div_next;
      pixel_tick <= tick_next_c;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel/line counters, sync decode and line/frame strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_LAST    = H_SYNC + H_BP + H_ACTIVE + H_FP - 1;
  localparam int unsigned V_LAST    = V_SYNC + V_BP + V_ACTIVE + V_FP - 1;
  localparam int unsigned H_VIS_BEG = H_SYNC + H_BP;
  localparam int unsigned H_VIS_END = H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned V_VIS_BEG = V_SYNC + V_BP;
  localparam int unsigned V_VIS_END = V_SYNC + V_BP + V_ACTIVE;

  logic   rst_arm_n;
  logic   rst_sync_n;
  logic   tick;
  logic   tick_next_c;

  coord_t x_q;
  coord_t y_q;
  coord_t x_next;
  coord_t y_next;

  logic   hsync_q;
  logic   vsync_q;
  logic   video_on_q;
  logic   line_start_q;
  logic   frame_start_q;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .rst_arm_n   (rst_arm_n),
    .rst_sync_n  (rst_sync_n),
    .pixel_tick  (tick),
    .tick_next_c (tick_next_c)
  );

  // Next raster position; held at (0,0) until the synchronised release.
  always_comb begin
    x_next = x_q;
    y_next = y_q;
    if (rst_sync_n && tick) begin
      if (x_q == coord_t'(H_LAST)) begin
        x_next = '0;
        y_next = (y_q == coord_t'(V_LAST)) ? '0 : y_q + coord_t'(1);
      end else begin
        x_next = x_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_next;
      y_q <= y_next;
    end
  end

  // Decoded from next-state counters so they land in the same cycle as pixel_x/pixel_y.
  always_ff @(posedge clk or negedge rst_arm_n) begin
    if (!rst_arm_n) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (x_next >= coord_t'(H_SYNC));
      vsync_q       <= (y_next >= coord_t'(V_SYNC));
      video_on_q    <= (x_next >= coord_t'(H_VIS_BEG)) && (x_next < coord_t'(H_VIS_END)) &&
                       (y_next >= coord_t'(V_VIS_BEG)) && (y_next < coord_t'(V_VIS_END));
      line_start_q  <= tick_next_c && (x_next == '0);
      frame_start_q <= tick_next_c && (x_next == '0) && (y_next == '0);
    end
  end

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixel_tick  = tick;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
